// File: rtl/oup_ulpi_pkg.sv
// Shared constants, state encoding and helpers for the ULPI PHY responder.
package oup_ulpi_pkg;

    // Command opcodes carried in ulpi_data_i[7:6] while idle
    localparam logic [1:0] CMD_NOOP = 2'b00;
    localparam logic [1:0] CMD_TX   = 2'b01;
    localparam logic [1:0] CMD_REGW = 2'b10;
    localparam logic [1:0] CMD_REGR = 2'b11;

    // Register map (base addresses; base+1 = set, base+2 = clear)
    localparam logic [5:0] ADDR_VID_LO = 6'h00;
    localparam logic [5:0] ADDR_VID_HI = 6'h01;
    localparam logic [5:0] ADDR_PID_LO = 6'h02;
    localparam logic [5:0] ADDR_PID_HI = 6'h03;
    localparam logic [5:0] ADDR_FUNC   = 6'h04;
    localparam logic [5:0] ADDR_IFC    = 6'h07;
    localparam logic [5:0] ADDR_OTG    = 6'h0A;
    localparam logic [5:0] ADDR_SCR    = 6'h16;

    localparam logic [7:0] FUNC_RST_VAL = 8'h41;
    localparam logic [7:0] IFC_RST_VAL  = 8'h00;
    localparam logic [7:0] OTG_RST_VAL  = 8'h06;
    localparam logic [7:0] SCR_RST_VAL  = 8'h00;

    // FunctionControl.Reset is self-clearing
    localparam int         FUNC_RESET_BIT  = 5;
    localparam logic [7:0] FUNC_RESET_MASK = 8'h20;

    // RX CMD field positions
    localparam int RXCMD_LS_LSB   = 0;
    localparam int RXCMD_VBUS_LSB = 2;
    localparam int RXCMD_EVT_LSB  = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ACK,
        ST_WR_DATA,
        ST_WR_STP,
        ST_RD_ACK,
        ST_RD_TA,
        ST_RD_DATA,
        ST_TX_DATA,
        ST_RX_TA,
        ST_RX_DATA,
        ST_TA_OUT
    } state_e;

    // True when addr falls in the write/set/clear triplet starting at base
    function automatic logic in_group(input logic [5:0] addr, input logic [5:0] base);
        return (addr >= base) && (addr <= base + 6'd2);
    endfunction

    // New register value for a write through one of the three aliases
    function automatic logic [7:0] reg_update(input logic [7:0] cur, input logic [7:0] wdata,
                                              input logic [5:0] addr, input logic [5:0] base);
        logic [5:0] off;
        off = addr - base;
        case (off)
            6'd0:    return wdata;
            6'd1:    return cur | wdata;
            default: return cur & ~wdata;
        endcase
    endfunction

    // RX CMD byte; RxEvent is always reported as 00
    function automatic logic [7:0] rxcmd_byte(input logic [1:0] vbus, input logic [1:0] ls);
        logic [7:0] b;
        b = '0;
        b[RXCMD_EVT_LSB +: 2]  = 2'b00;
        b[RXCMD_VBUS_LSB +: 2] = vbus;
        b[RXCMD_LS_LSB +: 2]   = ls;
        return b;
    endfunction

endpackage

// File: rtl/oup_ulpi_phy_regfile.sv
// Reduced ULPI register file: IDs, FunctionControl, InterfaceControl,
// OTGControl and Scratch with write/set/clear aliases.
module oup_ulpi_phy_regfile
    import oup_ulpi_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0006
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       we_i,
    output logic [7:0] rdata_o,
    output logic       phy_rst_o
);

    logic [7:0] func_q, func_d;
    logic [7:0] ifc_q,  ifc_d;
    logic [7:0] otg_q,  otg_d;
    logic [7:0] scr_q,  scr_d;
    logic       phy_rst_q, phy_rst_d;
    logic [7:0] func_new;

    // Next-state for the writable registers; Reset bit is turned into a pulse
    always_comb begin
        func_d    = func_q;
        ifc_d     = ifc_q;
        otg_d     = otg_q;
        scr_d     = scr_q;
        phy_rst_d = 1'b0;
        func_new  = reg_update(func_q, wdata_i, addr_i, ADDR_FUNC);
        if (we_i) begin
            if (in_group(addr_i, ADDR_FUNC)) begin
                func_d    = func_new & ~FUNC_RESET_MASK;
                phy_rst_d = func_new[FUNC_RESET_BIT];
            end
            if (in_group(addr_i, ADDR_IFC)) ifc_d = reg_update(ifc_q, wdata_i, addr_i, ADDR_IFC);
            if (in_group(addr_i, ADDR_OTG)) otg_d = reg_update(otg_q, wdata_i, addr_i, ADDR_OTG);
            if (in_group(addr_i, ADDR_SCR)) scr_d = reg_update(scr_q, wdata_i, addr_i, ADDR_SCR);
        end
    end

    // Register state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            func_q    <= FUNC_RST_VAL;
            ifc_q     <= IFC_RST_VAL;
            otg_q     <= OTG_RST_VAL;
            scr_q     <= SCR_RST_VAL;
            phy_rst_q <= 1'b0;
        end else begin
            func_q    <= func_d;
            ifc_q     <= ifc_d;
            otg_q     <= otg_d;
            scr_q     <= scr_d;
            phy_rst_q <= phy_rst_d;
        end
    end

    // Combinational read; unmapped addresses return zero
    always_comb begin
        rdata_o = 8'h00;
        if      (addr_i == ADDR_VID_LO)      rdata_o = VENDOR_ID[7:0];
        else if (addr_i == ADDR_VID_HI)      rdata_o = VENDOR_ID[15:8];
        else if (addr_i == ADDR_PID_LO)      rdata_o = PRODUCT_ID[7:0];
        else if (addr_i == ADDR_PID_HI)      rdata_o = PRODUCT_ID[15:8];
        else if (in_group(addr_i, ADDR_FUNC)) rdata_o = func_q;
        else if (in_group(addr_i, ADDR_IFC))  rdata_o = ifc_q;
        else if (in_group(addr_i, ADDR_OTG))  rdata_o = otg_q;
        else if (in_group(addr_i, ADDR_SCR))  rdata_o = scr_q;
    end

    assign phy_rst_o = phy_rst_q;

endmodule

// File: rtl/oup_ulpi_phy_responder.sv
// PHY side of the ULPI link: answers register accesses and transmits from
// the link, and reports LineState/VBUS changes as RX CMD bytes.
module oup_ulpi_phy_responder
    import oup_ulpi_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0006
) (
    input  logic       ulpi_clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_dir_o,
    output logic       ulpi_nxt_o,
    input  logic       ulpi_stp_i,
    input  logic [1:0] linestate_i,
    input  logic [1:0] vbus_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    output logic       tx_eop_o,
    output logic       phy_rst_o
);

    state_e     state_q;
    logic [5:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] data_q;
    logic       dir_q, nxt_q;
    logic [7:0] tx_data_q;
    logic       tx_valid_q, tx_eop_q;
    logic       pend_q, pend_d;
    logic [3:0] line_q;
    logic [3:0] line_now;
    logic       line_chg;
    logic       pend_now;
    logic       reg_we;
    logic [7:0] reg_rdata;

    assign line_now = {vbus_i, linestate_i};
    assign line_chg = (line_now != line_q);
    // A change seen this very cycle already counts as pending in IDLE
    assign pend_now = pend_q | line_chg;
    // Write commits on the cycle the link raises stp after the data byte
    assign reg_we   = (state_q == ST_WR_STP) && ulpi_stp_i;

    oup_ulpi_phy_regfile #(
        .VENDOR_ID (VENDOR_ID),
        .PRODUCT_ID(PRODUCT_ID)
    ) u_regfile (
        .clk_i    (ulpi_clk_i),
        .rst_n_i  (rst_n_i),
        .addr_i   (addr_q),
        .wdata_i  (wdata_q),
        .we_i     (reg_we),
        .rdata_o  (reg_rdata),
        .phy_rst_o(phy_rst_o)
    );

    // Pending flag: set on any change, cleared when the RX CMD byte is loaded
    always_comb begin
        pend_d = pend_q;
        if (line_chg) pend_d = 1'b1;
        if (state_q == ST_RX_TA) pend_d = 1'b0;
    end

    // Registered copy of line/VBUS state and the pending flag
    always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_q <= 4'h0;
            pend_q <= 1'b0;
        end else begin
            line_q <= line_now;
            pend_q <= pend_d;
        end
    end

    // Link protocol FSM with registered bus and strobe outputs
    always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= 6'h00;
            wdata_q    <= 8'h00;
            data_q     <= 8'h00;
            dir_q      <= 1'b0;
            nxt_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_eop_q   <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            tx_eop_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_now) begin
                        state_q <= ST_RX_TA;
                        dir_q   <= 1'b1;
                        data_q  <= 8'h00;
                    end else begin
                        case (ulpi_data_i[7:6])
                            CMD_TX: begin
                                state_q    <= ST_TX_DATA;
                                nxt_q      <= 1'b1;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= ulpi_data_i;
                            end
                            CMD_REGW: begin
                                state_q <= ST_WR_ACK;
                                nxt_q   <= 1'b1;
                                addr_q  <= ulpi_data_i[5:0];
                            end
                            CMD_REGR: begin
                                state_q <= ST_RD_ACK;
                                nxt_q   <= 1'b1;
                                addr_q  <= ulpi_data_i[5:0];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WR_ACK:  state_q <= ST_WR_DATA;
                ST_WR_DATA: begin
                    wdata_q <= ulpi_data_i;
                    nxt_q   <= 1'b0;
                    state_q <= ST_WR_STP;
                end
                ST_WR_STP: if (ulpi_stp_i) state_q <= ST_IDLE;
                ST_RD_ACK: begin
                    state_q <= ST_RD_TA;
                    dir_q   <= 1'b1;
                    nxt_q   <= 1'b0;
                end
                ST_RD_TA: begin
                    state_q <= ST_RD_DATA;
                    data_q  <= reg_rdata;
                end
                ST_TX_DATA: begin
                    if (ulpi_stp_i) begin
                        state_q  <= ST_IDLE;
                        nxt_q    <= 1'b0;
                        tx_eop_q <= 1'b1;
                    end else begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ulpi_data_i;
                    end
                end
                ST_RX_TA: begin
                    state_q <= ST_RX_DATA;
                    data_q  <= rxcmd_byte(vbus_i, linestate_i);
                end
                ST_RD_DATA, ST_RX_DATA: begin
                    state_q <= ST_TA_OUT;
                    dir_q   <= 1'b0;
                    data_q  <= 8'h00;
                end
                ST_TA_OUT: state_q <= ST_IDLE;
                default: begin
                    state_q <= ST_IDLE;
                    dir_q   <= 1'b0;
                    nxt_q   <= 1'b0;
                    data_q  <= 8'h00;
                end
            endcase
        end
    end

    assign ulpi_data_o = data_q;
    assign ulpi_dir_o  = dir_q;
    assign ulpi_nxt_o  = nxt_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_eop_o    = tx_eop_q;

endmodule

// File: tb/tb_oup_ulpi_phy_responder.sv
// Directed bench for the ULPI PHY responder.
module tb_oup_ulpi_phy_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       dir, nxt, stp;
    logic [1:0] ls, vbus;
    logic [7:0] tx_data;
    logic       tx_valid, tx_eop, phy_rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oup_ulpi_phy_responder dut (
        .ulpi_clk_i (clk),
        .rst_n_i    (rst_n),
        .ulpi_data_i(data_i),
        .ulpi_data_o(data_o),
        .ulpi_dir_o (dir),
        .ulpi_nxt_o (nxt),
        .ulpi_stp_i (stp),
        .linestate_i(ls),
        .vbus_i     (vbus),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_eop_o   (tx_eop),
        .phy_rst_o  (phy_rst)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [7:0] exp, input string tag);
        data_i = {2'b11, a};
        tick();
        chk({tag, " k nxt"}, 16'(nxt), 16'h1);
        chk({tag, " k dir"}, 16'(dir), 16'h0);
        data_i = 8'h00;
        tick();
        chk({tag, " k+1 dir"}, 16'(dir), 16'h1);
        chk({tag, " k+1 nxt"}, 16'(nxt), 16'h0);
        tick();
        chk({tag, " k+2 data"}, 16'(data_o), 16'(exp));
        chk({tag, " k+2 nxt"}, 16'(nxt), 16'h0);
        tick();
        chk({tag, " k+3 dir"}, 16'(dir), 16'h0);
        chk({tag, " k+3 data"}, 16'(data_o), 16'h0);
        tick();
    endtask

    // leaves the bench right after the commit edge
    task automatic do_write(input logic [5:0] a, input logic [7:0] wd, input string tag);
        data_i = {2'b10, a};
        tick();
        chk({tag, " k nxt"}, 16'(nxt), 16'h1);
        data_i = 8'h00;
        tick();
        chk({tag, " k+1 nxt"}, 16'(nxt), 16'h1);
        data_i = wd;
        tick();
        chk({tag, " k+2 nxt"}, 16'(nxt), 16'h0);
        data_i = 8'h00;
        stp = 1'b1;
        tick();
        stp = 1'b0;
    endtask

    task automatic rx_expect(input logic [7:0] exp, input string tag);
        tick();
        chk({tag, " dir up"}, 16'(dir), 16'h1);
        chk({tag, " nxt"}, 16'(nxt), 16'h0);
        tick();
        chk({tag, " rxcmd"}, 16'(data_o), 16'(exp));
        chk({tag, " dir hold"}, 16'(dir), 16'h1);
        tick();
        chk({tag, " dir down"}, 16'(dir), 16'h0);
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        data_i = 8'h00;
        stp    = 1'b0;
        ls     = 2'b00;
        vbus   = 2'b00;
        tick();
        tick();
        chk("rst dir", 16'(dir), 16'h0);
        chk("rst nxt", 16'(nxt), 16'h0);
        chk("rst data", 16'(data_o), 16'h0);
        chk("rst txv", 16'(tx_valid), 16'h0);
        chk("rst eop", 16'(tx_eop), 16'h0);
        chk("rst phyrst", 16'(phy_rst), 16'h0);
        rst_n = 1'b1;
        tick();
        chk("idle dir", 16'(dir), 16'h0);

        // ID and reset-value reads
        do_read(6'h00, 8'h24, "rd vid lo");
        do_read(6'h01, 8'h04, "rd vid hi");
        do_read(6'h02, 8'h06, "rd pid lo");
        do_read(6'h03, 8'h00, "rd pid hi");
        do_read(6'h0A, 8'h06, "rd otg");
        do_read(6'h0C, 8'h06, "rd otg clr alias");

        // scratch write / set / clear
        do_write(6'h16, 8'hA5, "wr scr");
        do_read(6'h16, 8'hA5, "rd scr");
        do_write(6'h17, 8'h0A, "set scr");
        do_read(6'h16, 8'hAF, "rd scr set");
        do_write(6'h18, 8'h05, "clr scr");
        do_read(6'h17, 8'hAA, "rd scr clr");

        // FunctionControl Reset bit
        do_read(6'h04, 8'h41, "rd func");
        do_write(6'h04, 8'h61, "wr func");
        chk("phy_rst pulse", 16'(phy_rst), 16'h1);
        tick();
        chk("phy_rst drop", 16'(phy_rst), 16'h0);
        do_read(6'h04, 8'h41, "rd func after");
        do_write(6'h05, 8'h20, "set func rst");
        chk("phy_rst set pulse", 16'(phy_rst), 16'h1);
        tick();
        chk("phy_rst set drop", 16'(phy_rst), 16'h0);

        // read-only and unmapped
        do_write(6'h00, 8'hFF, "wr vid");
        do_read(6'h00, 8'h24, "rd vid unchanged");
        do_write(6'h2F, 8'h55, "wr ext");
        do_read(6'h2F, 8'h00, "rd ext");

        // RX CMD on VBUS then LineState change
        vbus = 2'b11;
        rx_expect(8'h0C, "rx vbus");
        ls = 2'b01;
        rx_expect(8'h0D, "rx ls");
        tick();
        chk("rx quiet", 16'(dir), 16'h0);

        // two changes during a register write coalesce into one RX CMD
        data_i = 8'h87;
        tick();
        ls = 2'b10;
        data_i = 8'h00;
        tick();
        data_i = 8'h5A;
        tick();
        ls = 2'b11;
        data_i = 8'h00;
        stp = 1'b1;
        tick();
        stp = 1'b0;
        chk("wr ifc dir after commit", 16'(dir), 16'h0);
        rx_expect(8'h0F, "rx coalesced");
        tick();
        chk("rx once a", 16'(dir), 16'h0);
        tick();
        chk("rx once b", 16'(dir), 16'h0);
        do_read(6'h07, 8'h5A, "rd ifc");

        // transmit
        data_i = 8'h43;
        tick();
        chk("tx cmd valid", 16'(tx_valid), 16'h1);
        chk("tx cmd data", 16'(tx_data), 16'h43);
        chk("tx nxt", 16'(nxt), 16'h1);
        data_i = 8'h11;
        tick();
        chk("tx b1 valid", 16'(tx_valid), 16'h1);
        chk("tx b1 data", 16'(tx_data), 16'h11);
        data_i = 8'h22;
        tick();
        chk("tx b2 valid", 16'(tx_valid), 16'h1);
        chk("tx b2 data", 16'(tx_data), 16'h22);
        data_i = 8'h00;
        stp = 1'b1;
        tick();
        chk("tx eop", 16'(tx_eop), 16'h1);
        chk("tx stp valid", 16'(tx_valid), 16'h0);
        chk("tx stp nxt", 16'(nxt), 16'h0);
        stp = 1'b0;
        tick();
        chk("tx eop drop", 16'(tx_eop), 16'h0);
        do_read(6'h16, 8'hAA, "rd after tx");

        // pending RX CMD beats a simultaneous TXCMD
        ls = 2'b00;
        data_i = 8'h41;
        tick();
        chk("prio dir", 16'(dir), 16'h1);
        chk("prio txv", 16'(tx_valid), 16'h0);
        data_i = 8'h00;
        tick();
        chk("prio rxcmd", 16'(data_o), 16'h0C);
        tick();
        tick();

        // reset mid-write aborts; registers return to reset values
        data_i = 8'h96;
        tick();
        data_i = 8'h00;
        tick();
        data_i = 8'h33;
        tick();
        data_i = 8'h00;
        rst_n = 1'b0;
        #2;
        chk("midrst nxt", 16'(nxt), 16'h0);
        chk("midrst dir", 16'(dir), 16'h0);
        rst_n = 1'b1;
        stp = 1'b1;
        tick();
        // copy reset to 0 while vbus=11 => one RX CMD follows reset
        stp = 1'b0;
        chk("postrst dir", 16'(dir), 16'h1);
        tick();
        chk("postrst rxcmd", 16'(data_o), 16'h0C);
        tick();
        tick();
        do_read(6'h16, 8'h00, "rd scr after rst");
        do_read(6'h04, 8'h41, "rd func after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oup_ulpi_phy_responder.md
# oup_ulpi_phy_responder

PHY-side end of the ULPI link used by the OUP device controller. It answers link-initiated register writes, register reads and transmit commands, and sends RX CMD bytes when line or VBUS state changes. It holds a reduced ULPI register file. It is the synthesizable counterpart for the controller's ULPI state machine: it serves as a loopback/emulation PHY on FPGA and as the bench responder for the link.

## Interface

Parameters:
- VENDOR_ID, 16'h0424: returned at addresses 0x00 (low byte) and 0x01 (high byte).
- PRODUCT_ID, 16'h0006: returned at addresses 0x02 (low byte) and 0x03 (high byte).

Ports (one clock; reset is asynchronous and active-low):
- ulpi_clk_i  in  1  sole clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- ulpi_data_i  in  8  byte driven by the link; ignored while ulpi_dir_o=1.
- ulpi_data_o  out  8  PHY byte; valid only while ulpi_dir_o=1, otherwise 8'h00.
- ulpi_dir_o  out  1  bus direction; 1 = PHY drives.
- ulpi_nxt_o  out  1  PHY throttle.
- ulpi_stp_i  in  1  link stop.
- linestate_i  in  2  emulated LineState.
- vbus_i  in  2  emulated VBUS state.
- tx_data_o  out  8  byte consumed from a link transmit.
- tx_valid_o  out  1  one-cycle strobe per tx_data_o byte.
- tx_eop_o  out  1  one-cycle strobe when a transmit ends on stp.
- phy_rst_o  out  1  one-cycle pulse when FunctionControl.Reset is written to 1.

## Operation

- Decoding of ulpi_data_i[7:6] in IDLE:
  - 00: NOOP.
  - 01: TRANSMIT.
  - 10: REGWRITE, address in [5:0].
  - 11: REGREAD, address in [5:0].
- State machine states: IDLE, WR_ACK, WR_DATA, WR_STP, RD_ACK, RD_TA, RD_DATA, TX_DATA, RX_TA, RX_DATA, TA_OUT.
- Register file:
  - 0x00–0x03: IDs, read-only; writes are ignored.
  - 0x04/05/06: FunctionControl, reset value 8'h41.
  - 0x07/08/09: InterfaceControl, reset value 8'h00.
  - 0x0A/0B/0C: OTGControl, reset value 8'h06.
  - 0x16/17/18: Scratch, reset value 8'h00.
  - Write semantics per register group: base address = write, base+1 = set (OR), base+2 = clear (AND-NOT).
  - Reads at base, base+1 and base+2 all return the register value.
- FunctionControl bit 5 (Reset) self-clears: writing 1 pulses phy_rst_o, and bit 5 never reads back as 1.
- Unmapped addresses, including extended address 0x2F: the handshake completes, write data is discarded, and reads return 8'h00.
- RX CMD byte layout: {1'b0, 1'b0, 2'b00 RxEvent, vbus_i, linestate_i}.
- RX CMD pending flag:
  - Set whenever {vbus_i, linestate_i} differs from its registered copy.
  - Cleared when RX_DATA is loaded.
  - RX_DATA always sends the current values, so multiple changes coalesce into one RX CMD.
- Transmit path:
  - The TXCMD byte itself is emitted first on tx_data_o.
  - Every byte the link presents while ulpi_nxt_o=1 and ulpi_stp_i=0 is then emitted.
  - The data byte presented with stp is not emitted.

## Timing

- Reset: state IDLE; dir, nxt, tx_valid, tx_eop and phy_rst all 0; data_o = 8'h00; pending = 0; registers at reset values. Reset mid-transaction aborts immediately and no write commits.
- Edge k denotes the edge at which IDLE samples the command.
- REGWRITE:
  - Edge k → WR_ACK, nxt=1.
  - Edge k+1 → WR_DATA, nxt=1.
  - Edge k+2: latch data → WR_STP, nxt=0.
  - WR_STP waits for stp=1, then commits the write and goes → IDLE.
- REGREAD:
  - Edge k → RD_ACK, nxt=1.
  - Edge k+1 → RD_TA, dir=1, nxt=0.
  - Edge k+2 → RD_DATA, data_o = register value.
  - Edge k+3 → TA_OUT, dir=0.
  - Edge k+4 → IDLE.
- TRANSMIT:
  - Edge k → TX_DATA, nxt=1, tx_valid=1, tx_data = TXCMD byte.
  - Each later edge with stp=0 emits one byte.
  - The edge with stp=1 gives tx_eop=1, nxt=0 → IDLE.
- RX CMD:
  - IDLE with pending=1 → RX_TA, dir=1.
  - Next edge → RX_DATA, data_o = RX CMD.
  - Next edge → TA_OUT, dir=0.
  - Next edge → IDLE.
- Priority in IDLE: pending RX CMD wins over a simultaneous TXCMD. The TXCMD is ignored and the link must retry.
- Changes during a transaction: pending latches and the RX CMD is sent on the first IDLE after the transaction.
- TA_OUT: ulpi_data_i is ignored for that one cycle.
- stp sampled in IDLE: ignored.

## Structure

- Package oup_ulpi_pkg:
  - TXCMD opcode constants.
  - Register address constants and reset values.
  - State enum typedef.
  - RX CMD field positions.
- Sub-module oup_ulpi_phy_regfile:
  - Inputs: addr, wdata, write strobe.
  - Output: combinational read data.
  - Implements set/clear aliasing, the self-clearing Reset bit and phy_rst pulse generation.

## Test plan

- Reset, then REGREAD 0x00 → dir=1 at k+1; data_o=8'h24 at k+2; dir=0 at k+3; nxt never high after k+1.
- REGWRITE 0x16←A5, readback A5; set 0x17←0A → AF; clear 0x18←05 → AA.
- Read 0x04 → 41; write 0x04←61 → phy_rst_o high for exactly 1 cycle, readback 41.
- vbus_i=11, linestate_i 00→01 in IDLE → dir rises next edge; data_o=8'h0D one cycle later; dir low after.
- linestate_i changes twice during a REGWRITE to 0x07 → write commits, then exactly one RX CMD with final state.
- TXCMD 8'h43, bytes 11, 22, then stp with 00 → tx_valid bytes 43, 11, 22; tx_eop pulse; returns to IDLE.
